// File: rtl/bemf_sequencer.sv
// Back-EMF frame sequencer: inhibits PWM, settles, samples H/L per motor, issues to bemf_update, writes results back.
// Optional BEMF_ADC_TIMEOUT_EN: abort the frame and set sticky adc_err when adc_ack misses ADC_TIMEOUT cycles.
module bemf_sequencer #(
    parameter int SETTLE_CYCLES = 400,
    parameter int ADC_TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_start,
    output logic        pwm_inhibit,
    output logic        adc_req,
    output logic [2:0]  adc_chan,
    input  logic        adc_ack,
    input  logic [9:0]  adc_data,
    input  logic        calib_wr,
    input  logic [1:0]  calib_sel,
    input  logic [19:0] calib_data,
    input  logic [3:0]  bemf_clr,
    output logic [9:0]  upd_adc_h,
    output logic [9:0]  upd_adc_l,
    output logic [1:0]  upd_mot_sel,
    output logic        upd_valid,
    output logic [19:0] upd_acc,
    output logic [19:0] upd_calib,
    input  logic        res_valid,
    input  logic [1:0]  res_mot_sel,
    input  logic [19:0] res_pos,
    input  logic [19:0] res_vel,
    input  logic [1:0]  rd_sel,
    output logic [19:0] rd_pos,
    output logic [19:0] rd_vel,
    output logic        busy,
    output logic        frame_done,
    output logic        adc_err
);
    // One down-counter serves both the settle wait and the ADC ack timeout.
    localparam int CMAX = (SETTLE_CYCLES > ADC_TIMEOUT) ? SETTLE_CYCLES : ADC_TIMEOUT;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX + 1) : 1;
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
`ifdef BEMF_ADC_TIMEOUT_EN
    localparam logic [CW-1:0] TMO_LOAD = CW'(ADC_TIMEOUT - 1);
`endif

    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_SAMP_H, S_SAMP_L, S_ISSUE, S_DRAIN} state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [1:0]        m_q;
    logic [9:0]        h_q;
    logic              pwm_q, busy_q, done_q, adc_req_q;
    logic [2:0]        adc_chan_q;
    logic              upd_valid_q;
    logic [1:0]        upd_mot_sel_q;
    logic [9:0]        upd_adc_h_q, upd_adc_l_q;
    logic [19:0]       upd_acc_q, upd_calib_q;
    logic [3:0][19:0]  acc_q, vel_q, calib_q;
    logic [19:0]       rd_pos_q, rd_vel_q;
    logic [2:0]        infl_q, infl_d;
    logic [3:0]        pend_q, discard_q, iss_oh, res_oh;
    logic              frame_end;
`ifdef BEMF_ADC_TIMEOUT_EN
    logic              adc_err_q;
`endif

    assign frame_end = (state_q == S_DRAIN) && (infl_q == '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            m_q           <= '0;
            h_q           <= '0;
            pwm_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            adc_req_q     <= 1'b0;
            adc_chan_q    <= '0;
            upd_valid_q   <= 1'b0;
            upd_mot_sel_q <= '0;
            upd_adc_h_q   <= '0;
            upd_adc_l_q   <= '0;
            upd_acc_q     <= '0;
            upd_calib_q   <= '0;
`ifdef BEMF_ADC_TIMEOUT_EN
            adc_err_q     <= 1'b0;
`endif
        end else begin
            upd_valid_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (frame_start) begin
                        state_q <= S_SETTLE;
                        pwm_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        cnt_q   <= SETTLE_LOAD;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_q    <= S_SAMP_H;
                        m_q        <= '0;
                        adc_req_q  <= 1'b1;
                        adc_chan_q <= 3'b001;
`ifdef BEMF_ADC_TIMEOUT_EN
                        cnt_q      <= TMO_LOAD;
`endif
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_SAMP_H, S_SAMP_L: begin
                    // A low adc_req here is the mandatory idle cycle between requests.
                    if (!adc_req_q) begin
                        adc_req_q  <= 1'b1;
                        adc_chan_q <= {m_q, state_q == S_SAMP_H};
`ifdef BEMF_ADC_TIMEOUT_EN
                        cnt_q      <= TMO_LOAD;
`endif
                    end else if (adc_ack) begin
                        adc_req_q <= 1'b0;
                        if (state_q == S_SAMP_H) begin
                            h_q     <= adc_data;
                            state_q <= S_SAMP_L;
                        end else begin
                            state_q       <= S_ISSUE;
                            upd_valid_q   <= 1'b1;
                            upd_adc_h_q   <= h_q;
                            upd_adc_l_q   <= adc_data;
                            upd_mot_sel_q <= m_q;
                            upd_acc_q     <= acc_q[m_q];
                            upd_calib_q   <= calib_q[m_q];
                        end
`ifdef BEMF_ADC_TIMEOUT_EN
                    end else if (cnt_q == '0) begin
                        adc_req_q <= 1'b0;
                        adc_err_q <= 1'b1;
                        state_q   <= S_DRAIN;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
`endif
                    end
                end
                S_ISSUE: begin
                    if (m_q == 2'd3) begin
                        state_q <= S_DRAIN;
                    end else begin
                        m_q     <= m_q + 1'b1;
                        state_q <= S_SAMP_H;
                    end
                end
                S_DRAIN: begin
                    if (infl_q == '0) begin
                        done_q  <= 1'b1;
                        pwm_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        iss_oh = '0;
        res_oh = '0;
        if (upd_valid_q) iss_oh[upd_mot_sel_q] = 1'b1;
        if (res_valid)   res_oh[res_mot_sel]   = 1'b1;
    end

    always_comb begin
        infl_d = infl_q;
        case ({upd_valid_q, res_valid})
            2'b10:   infl_d = infl_q + 3'd1;
            2'b01:   infl_d = infl_q - 3'd1;
            default: infl_d = infl_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            infl_q    <= '0;
            pend_q    <= '0;
            discard_q <= '0;
            acc_q     <= '0;
            vel_q     <= '0;
            calib_q   <= '0;
            rd_pos_q  <= '0;
            rd_vel_q  <= '0;
        end else begin
            infl_q <= infl_d;
            pend_q <= (pend_q & ~res_oh) | iss_oh;
            // A clear racing an in-flight update must also kill that update's late writeback.
            if (frame_end) discard_q <= '0;
            else discard_q <= (discard_q & ~res_oh) | (bemf_clr & ((pend_q & ~res_oh) | iss_oh));
            for (int k = 0; k < 4; k++) begin
                if (bemf_clr[k]) begin
                    acc_q[k] <= '0;
                    vel_q[k] <= '0;
                end else if (res_oh[k] && !discard_q[k]) begin
                    acc_q[k] <= res_pos;
                    vel_q[k] <= res_vel;
                end
            end
            if (calib_wr) calib_q[calib_sel] <= calib_data;
            rd_pos_q <= acc_q[rd_sel];
            rd_vel_q <= vel_q[rd_sel];
        end
    end

    assign pwm_inhibit = pwm_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign adc_req     = adc_req_q;
    assign adc_chan    = adc_chan_q;
    assign upd_valid   = upd_valid_q;
    assign upd_mot_sel = upd_mot_sel_q;
    assign upd_adc_h   = upd_adc_h_q;
    assign upd_adc_l   = upd_adc_l_q;
    assign upd_acc     = upd_acc_q;
    assign upd_calib   = upd_calib_q;
    assign rd_pos      = rd_pos_q;
    assign rd_vel      = rd_vel_q;
`ifdef BEMF_ADC_TIMEOUT_EN
    assign adc_err     = adc_err_q;
`else
    assign adc_err     = 1'b0;
`endif

endmodule

// File: tb/tb_bemf_sequencer.sv
// Randomized bench for bemf_sequencer: ADC responder, 4-cycle bemf_update stub, frame-level reference model.
module tb_bemf_sequencer;
    localparam int SETTLE = 4;
    localparam int TMO    = 8;

    logic        clk = 1'b0, reset_n = 1'b0, frame_start = 1'b0;
    logic        pwm_inhibit, adc_req, adc_ack = 1'b0;
    logic [2:0]  adc_chan;
    logic [9:0]  adc_data = '0;
    logic        calib_wr = 1'b0;
    logic [1:0]  calib_sel = '0;
    logic [19:0] calib_data = '0;
    logic [3:0]  bemf_clr = '0;
    logic [9:0]  upd_adc_h, upd_adc_l;
    logic [1:0]  upd_mot_sel;
    logic        upd_valid;
    logic [19:0] upd_acc, upd_calib;
    logic        res_valid = 1'b0;
    logic [1:0]  res_mot_sel = '0;
    logic [19:0] res_pos = '0, res_vel = '0;
    logic [1:0]  rd_sel = '0;
    logic [19:0] rd_pos, rd_vel;
    logic        busy, frame_done, adc_err;

    always #5 clk = ~clk;

    bemf_sequencer #(.SETTLE_CYCLES(SETTLE), .ADC_TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .pwm_inhibit(pwm_inhibit),
        .adc_req(adc_req), .adc_chan(adc_chan), .adc_ack(adc_ack), .adc_data(adc_data),
        .calib_wr(calib_wr), .calib_sel(calib_sel), .calib_data(calib_data), .bemf_clr(bemf_clr),
        .upd_adc_h(upd_adc_h), .upd_adc_l(upd_adc_l), .upd_mot_sel(upd_mot_sel), .upd_valid(upd_valid),
        .upd_acc(upd_acc), .upd_calib(upd_calib), .res_valid(res_valid), .res_mot_sel(res_mot_sel),
        .res_pos(res_pos), .res_vel(res_vel), .rd_sel(rd_sel), .rd_pos(rd_pos), .rd_vel(rd_vel),
        .busy(busy), .frame_done(frame_done), .adc_err(adc_err)
    );

    int n_chk = 0, n_err = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    logic [19:0] acc_m [4], vel_m [4], calib_m [4], nxt_acc [4], nxt_vel [4];
    logic [9:0]  adc_val [8];
    bit          issued [4], dropped [4];
    int          iss_cyc [4];
    int          issue_cnt = 0, chan_idx = 0, fd_cnt = 0, adc_lat = 2;
    bit          withhold_en = 0, first_req = 0;
    logic [2:0]  withhold_ch = '0;

    // Expected request order: motor-major, high side before low side.
    function automatic logic [2:0] exp_chan(input int idx);
        return 3'((idx / 2) * 2 + ((idx % 2 == 0) ? 1 : 0));
    endfunction

    initial begin : adc_model
        int w;
        w = 0;
        forever begin
            @(negedge clk);
            if (adc_ack) begin
                adc_ack = 1'b0;
                w = 0;
            end else if (adc_req && !(withhold_en && adc_chan == withhold_ch)) begin
                w++;
                if (w >= adc_lat) begin
                    adc_ack  = 1'b1;
                    adc_data = 10'($urandom);
                    adc_val[adc_chan] = adc_data;
                    chk($sformatf("adc_chan[%0d]", chan_idx), adc_chan, exp_chan(chan_idx));
                    chan_idx++;
                end
            end else begin
                w = 0;
            end
        end
    end

    typedef struct {int due; logic [1:0] sel; logic [19:0] pos; logic [19:0] vel;} res_t;
    res_t rq [$];

    initial begin : update_stub
        forever begin
            @(negedge clk);
            if (rq.size() > 0 && rq[0].due == cyc) begin
                res_valid   = 1'b1;
                res_mot_sel = rq[0].sel;
                res_pos     = rq[0].pos;
                res_vel     = rq[0].vel;
                void'(rq.pop_front());
            end else begin
                res_valid = 1'b0;
            end
            if (upd_valid)
                rq.push_back('{due: cyc + 4, sel: upd_mot_sel, pos: upd_acc + 20'd100,
                               vel: upd_calib + 20'(upd_adc_h) + 20'(upd_adc_l)});
        end
    end

    initial begin : monitor
        bit inh_prev, req_prev;
        int inh_t, m;
        inh_prev = 0; req_prev = 0; inh_t = 0;
        forever begin
            @(negedge clk);
            if (frame_done) fd_cnt++;
            if (pwm_inhibit && !inh_prev) inh_t = cyc;
            if (adc_req && !req_prev && first_req) begin
                chk("settle_latency", cyc - inh_t, SETTLE);
                first_req = 0;
            end
            inh_prev = pwm_inhibit;
            req_prev = adc_req;
            if (upd_valid) begin
                m = issue_cnt % 4;
                chk("upd_mot_sel", upd_mot_sel, m);
                chk("upd_adc_h", upd_adc_h, adc_val[m * 2 + 1]);
                chk("upd_adc_l", upd_adc_l, adc_val[m * 2]);
                chk("upd_acc", upd_acc, acc_m[m]);
                chk("upd_calib", upd_calib, calib_m[m]);
                nxt_acc[m] = acc_m[m] + 20'd100;
                nxt_vel[m] = calib_m[m] + 20'(adc_val[m * 2 + 1]) + 20'(adc_val[m * 2]);
                issued[m]  = 1;
                iss_cyc[m] = cyc;
                issue_cnt++;
            end
        end
    end

    task automatic write_calib(input int sel, input logic [19:0] val);
        @(negedge clk); #1;
        calib_wr = 1'b1; calib_sel = 2'(sel); calib_data = val;
        @(negedge clk); #1;
        calib_wr = 1'b0;
        calib_m[sel] = val;
    endtask

    task automatic read_one(input int k, output logic [19:0] p, output logic [19:0] v);
        @(negedge clk); #1;
        rd_sel = 2'(k);
        @(negedge clk); #1;
        p = rd_pos;
        v = rd_vel;
    endtask

    task automatic readback_all();
        logic [19:0] p, v;
        for (int k = 0; k < 4; k++) begin
            read_one(k, p, v);
            chk($sformatf("rd_pos[%0d]", k), p, acc_m[k]);
            chk($sformatf("rd_vel[%0d]", k), v, vel_m[k]);
        end
    endtask

    // mode 0 normal, 1 extra frame_start in SETTLE and DRAIN, 2 clear motor 2 in flight, 3 timeout frame
    task automatic run_frame(input int mode, input int exp_iss);
        int fd0, t_start, t_end;
        bit seen, extra_done, clr_done;
        for (int k = 0; k < 4; k++) begin issued[k] = 0; dropped[k] = 0; end
        issue_cnt = 0; chan_idx = 0; first_req = 1; fd0 = fd_cnt;
        seen = 0; extra_done = 0; clr_done = 0; t_start = -1; t_end = -1;
        @(negedge clk); #1 frame_start = 1'b1;
        @(negedge clk); #1 frame_start = 1'b0;
        if (mode == 1) begin
            @(negedge clk); #1 frame_start = 1'b1;
        end
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk); #1;
            frame_start = 1'b0;
            bemf_clr    = '0;
            if (mode == 1 && !extra_done && issue_cnt == 4 && cyc == iss_cyc[3] + 1) begin
                frame_start = 1'b1;
                extra_done  = 1;
            end
            if (mode == 2 && !clr_done && issue_cnt >= 3 && cyc == iss_cyc[2] + 2) begin
                bemf_clr   = 4'b0100;
                clr_done   = 1;
                acc_m[2]   = '0;
                vel_m[2]   = '0;
                dropped[2] = 1;
            end
            if (mode == 3) begin
                if (adc_req && adc_chan == withhold_ch && t_start < 0) t_start = cyc;
                if (t_start >= 0 && !adc_req && t_end < 0) t_end = cyc;
            end
            if (frame_done) seen = 1;
        end
        frame_start = 1'b0;
        bemf_clr    = '0;
        chk("frame_done_seen", seen, 1);
        chk("pwm_after_frame", pwm_inhibit, 0);
        if (mode == 1) begin
            repeat (20) @(negedge clk);
            #1 chk("busy_after_ignored_starts", busy, 0);
        end
        if (mode == 3) chk("timeout_req_len", t_end - t_start, TMO);
        chk("frame_done_count", fd_cnt - fd0, 1);
        chk("issue_count", issue_cnt, exp_iss);
        for (int k = 0; k < 4; k++)
            if (issued[k] && !dropped[k]) begin
                acc_m[k] = nxt_acc[k];
                vel_m[k] = nxt_vel[k];
            end
        readback_all();
    endtask

    initial begin : watchdog
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    initial begin : main
        logic [19:0] p, v;
        bit hit;
        for (int k = 0; k < 4; k++) begin acc_m[k] = '0; vel_m[k] = '0; calib_m[k] = '0; end
        for (int k = 0; k < 8; k++) adc_val[k] = '0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_pwm_inhibit", pwm_inhibit, 0);
        chk("rst_adc_req", adc_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_upd_valid", upd_valid, 0);
        chk("rst_rd_pos", rd_pos, 0);
        chk("rst_adc_err", adc_err, 0);
        reset_n = 1'b1;

        write_calib(1, 20'd5);
        write_calib(0, 20'($urandom));
        write_calib(2, 20'($urandom));
        write_calib(3, 20'($urandom));
        adc_lat = 2;
        run_frame(0, 4);
        adc_lat = $urandom_range(4, 1);
        run_frame(0, 4);
        read_one(1, p, v);
        chk("acc1_after_two_frames", p, 200);

        adc_lat = $urandom_range(4, 1);
        run_frame(1, 4);
        adc_lat = $urandom_range(4, 1);
        run_frame(2, 4);

        @(negedge clk); #1 bemf_clr = 4'b0001;
        @(negedge clk); #1 bemf_clr = 4'b0000;
        acc_m[0] = '0; vel_m[0] = '0;
        readback_all();
        run_frame(0, 4);

        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 4; k++) write_calib(k, 20'($urandom));
            adc_lat = $urandom_range(4, 1);
            run_frame(0, 4);
        end

`ifdef BEMF_ADC_TIMEOUT_EN
        withhold_en = 1; withhold_ch = 3'b010;
        adc_lat = 2;
        run_frame(3, 1);
        chk("adc_err_set", adc_err, 1);
        withhold_en = 0;
        run_frame(0, 4);
        chk("adc_err_sticky", adc_err, 1);
`else
        chk("adc_err_tied_low", adc_err, 0);
`endif

        // Reset while the motor 0 low-side request is pending
        adc_lat = 2; issue_cnt = 0; chan_idx = 0; first_req = 1; hit = 0;
        @(negedge clk); #1 frame_start = 1'b1;
        @(negedge clk); #1 frame_start = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk); #1;
            if (adc_req && adc_chan == 3'b000) begin
                hit = 1;
                reset_n = 1'b0;
            end
        end
        chk("reached_samp_l", hit, 1);
        @(negedge clk); #1;
        chk("midrst_adc_req", adc_req, 0);
        chk("midrst_pwm_inhibit", pwm_inhibit, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_upd_valid", upd_valid, 0);
        reset_n = 1'b1;
        rq.delete();
        for (int k = 0; k < 4; k++) begin acc_m[k] = '0; vel_m[k] = '0; calib_m[k] = '0; end
        readback_all();
        adc_lat = $urandom_range(4, 1);
        run_frame(0, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
